// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller for a classic five-stage pipeline.
// Resolves memory wait, taken-branch flush and load-use stalls by priority,
// and keeps a memory-wait watchdog plus two saturating performance counters.
module hazard_stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_uses_rs2,
  input  logic        branch_taken,
  input  logic        exmem_memread,
  input  logic        exmem_memwrite,
  input  logic        dmem_ready,
  input  logic        counter_clr,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        idex_bubble,
  output logic        exmem_hold,
  output logic        memwb_bubble,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic load_use;
  logic mem_busy;

  // Hazard detection: EX-stage load feeding an ID-stage source, and an unfinished data access.
  always_comb begin
    load_use = idex_memread && (idex_rd != 5'd0) &&
               ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    mem_busy = (exmem_memread || exmem_memwrite) && !dmem_ready;
  end

  // Prioritised control outputs and next state; a wait ends in the same cycle dmem_ready rises.
  always_comb begin
    // NOTE: every output gets a default before the branches, so no path can leave one unassigned and infer a latch.
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    state_d      = state_q;

    if (rst) begin
      // Reset drops any pending wait at once and fills the front of the pipe with NOPs.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      state_d      = RUN;
    end else if (mem_busy) begin
      // Freeze everything upstream of MEM; a held branch waits here and flushes on release.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
      state_d      = MEM_WAIT;
    end else begin
      state_d = RUN;
      if (branch_taken) begin
        // The redirect squashes the younger instructions, so a load-use stall on them is moot.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Watchdog and performance counter next values; clear and reset win over any increment.
  always_comb begin
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;

    if (rst || !mem_busy) begin
      wait_cnt_d = 8'd0;
    end else if ((state_q == MEM_WAIT) && (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    if (rst) begin
      mem_timeout_d = 1'b0;
    end else if (wait_cnt_d == 8'hFF) begin
      mem_timeout_d = 1'b1;
    end

    if (rst || counter_clr) begin
      stall_cycles_d = 16'd0;
      flush_count_d  = 16'd0;
    end else begin
      if (!pc_write && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_d = stall_cycles_q + 16'd1;
      end
      if (ifid_flush && (flush_count_q != 16'hFFFF)) begin
        flush_count_d = flush_count_q + 16'd1;
      end
    end
  end

  // State and counter registers; reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    state_q        <= state_d;
    wait_cnt_q     <= wait_cnt_d;
    mem_timeout_q  <= mem_timeout_d;
    stall_cycles_q <= stall_cycles_d;
    flush_count_q  <= flush_count_d;
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a table of single-cycle vectors,
// hand-written multi-cycle sequences, and a scoreboard queue of expectations.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        idex_memread;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_uses_rs2;
  logic        branch_taken;
  logic        exmem_memread;
  logic        exmem_memwrite;
  logic        dmem_ready;
  logic        counter_clr;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        idex_bubble;
  logic        exmem_hold;
  logic        memwb_bubble;
  logic        mem_timeout;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  hazard_stall_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .idex_memread  (idex_memread),
    .idex_rd       (idex_rd),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_uses_rs2 (ifid_uses_rs2),
    .branch_taken  (branch_taken),
    .exmem_memread (exmem_memread),
    .exmem_memwrite(exmem_memwrite),
    .dmem_ready    (dmem_ready),
    .counter_clr   (counter_clr),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .idex_bubble   (idex_bubble),
    .exmem_hold    (exmem_hold),
    .memwb_bubble  (memwb_bubble),
    .mem_timeout   (mem_timeout),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  // Control bundle order: {pc_write, ifid_write, ifid_flush, idex_flush, idex_bubble, exmem_hold, memwb_bubble}
  localparam logic [6:0] C_NONE = 7'b1100000;
  localparam logic [6:0] C_LU   = 7'b0000100;
  localparam logic [6:0] C_BR   = 7'b1111000;
  localparam logic [6:0] C_HOLD = 7'b0000011;
  localparam logic [6:0] C_RST  = 7'b0011001;

  typedef struct {
    string      name;
    logic       rst;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic       br;
    logic       exr;
    logic       exw;
    logic       rdy;
    logic       clr;
    logic [6:0] ctrl;
    logic       tmo;
  } vec_t;

  vec_t        sb_q[$];
  vec_t        tbl[12];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_stall = 16'd0;
  logic [15:0] m_flush = 16'd0;

  function automatic vec_t mk(input string n, input logic r, input logic mr,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u2, input logic br, input logic exr, input logic exw,
                              input logic rdy, input logic clr, input logic [6:0] ctrl,
                              input logic tmo);
    vec_t v;
    v.name = n; v.rst = r; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.u2 = u2; v.br = br; v.exr = exr; v.exw = exw; v.rdy = rdy; v.clr = clr;
    v.ctrl = ctrl; v.tmo = tmo;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst            = v.rst;
    idex_memread   = v.mr;
    idex_rd        = v.rd;
    ifid_rs1       = v.rs1;
    ifid_rs2       = v.rs2;
    ifid_uses_rs2  = v.u2;
    branch_taken   = v.br;
    exmem_memread  = v.exr;
    exmem_memwrite = v.exw;
    dmem_ready     = v.rdy;
    counter_clr    = v.clr;
  endtask

  // Counter model advances from the expected controls of the cycle just checked.
  task automatic model_update(input vec_t v);
    if (v.rst || v.clr) begin
      m_stall = 16'd0;
      m_flush = 16'd0;
    end else begin
      if (!v.ctrl[6] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (v.ctrl[4] && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    sb_q.push_back(v);
    #2;
    e = sb_q.pop_front();
    check({e.name, ".ctrl"}, {9'd0, pc_write, ifid_write, ifid_flush, idex_flush,
                              idex_bubble, exmem_hold, memwb_bubble}, {9'd0, e.ctrl});
    check({e.name, ".stall"}, stall_cycles, m_stall);
    check({e.name, ".flush"}, flush_count, m_flush);
    check({e.name, ".tmo"}, {15'd0, mem_timeout}, {15'd0, e.tmo});
    model_update(e);
  endtask

  task automatic drive_only(input vec_t v);
    @(negedge clk);
    drive(v);
    model_update(v);
  endtask

  initial begin
    vec_t idle, busy;
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0);
    busy = mk("mem_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_HOLD, 0);

    tbl[0]  = mk("none",        0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, C_NONE, 0);
    tbl[1]  = mk("lu_rs1",      0, 1, 5'd5, 5'd5, 5'd1, 0, 0, 0, 0, 1, 0, C_LU,   0);
    tbl[2]  = mk("lu_rd0",      0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 1, 0, C_NONE, 0);
    tbl[3]  = mk("lu_rs2",      0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0, 1, 0, C_LU,   0);
    tbl[4]  = mk("rs2_unused",  0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, 1, 0, C_NONE, 0);
    tbl[5]  = mk("no_load",     0, 0, 5'd5, 5'd5, 5'd5, 1, 0, 0, 0, 1, 0, C_NONE, 0);
    tbl[6]  = mk("branch",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 1, 0, C_BR,   0);
    tbl[7]  = mk("branch_lu",   0, 1, 5'd9, 5'd9, 5'd0, 0, 1, 0, 0, 1, 0, C_BR,   0);
    tbl[8]  = mk("store_ready", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, C_NONE, 0);
    tbl[9]  = mk("rst_mid",     1, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0, 1, 0, C_RST,  0);
    tbl[10] = mk("clr_stall",   0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0, 1, 1, C_LU,   0);
    tbl[11] = mk("after_clr",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, C_NONE, 0);

    // Initial reset: two edges with rst high, then the model starts from zero.
    drive(mk("init", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0));
    repeat (2) @(posedge clk);
    m_stall = 16'd0;
    m_flush = 16'd0;
    step(mk("reset_out", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0));

    for (int i = 0; i < 12; i++) step(tbl[i]);

    // Three-cycle load wait, released in the dmem_ready cycle.
    for (int i = 0; i < 3; i++) step(busy);
    step(mk("ld_release", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_NONE, 0));
    step(idle);

    // Branch held across a two-cycle store wait flushes only on release.
    for (int i = 0; i < 2; i++) step(mk("br_wait", 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, C_HOLD, 0));
    step(mk("br_release", 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, C_BR, 0));
    step(idle);

    // Release into a load-use hazard gives one bubble in the release cycle.
    step(busy);
    step(mk("rel_lu", 0, 1, 5'd6, 5'd6, 5'd0, 0, 0, 1, 0, 1, 0, C_LU, 0));
    step(idle);

    // Reset during a wait abandons the hold immediately.
    step(busy);
    step(busy);
    step(mk("rst_in_wait", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_RST, 0));
    step(idle);

    // Watchdog: 300 busy cycles; it reports after the 256th (first one is still in RUN).
    for (int k = 1; k <= 300; k++) begin
      vec_t v;
      v = busy;
      v.name = "tmo_wait";
      v.tmo = (k >= 257);
      step(v);
    end
    step(mk("tmo_release", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_NONE, 1));
    step(mk("tmo_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 1));
    step(mk("tmo_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 1));
    step(mk("tmo_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0));

    // Saturate the stall counter with load-use stalls, then clear together with a stall.
    for (int i = 0; i < 65600; i++)
      drive_only(mk("sat_fill", 0, 1, 5'd2, 5'd2, 5'd0, 0, 0, 0, 0, 1, 0, C_LU, 0));
    step(mk("sat_stall", 0, 1, 5'd2, 5'd2, 5'd0, 0, 0, 0, 0, 1, 0, C_LU, 0));
    step(mk("sat_clr", 0, 1, 5'd2, 5'd2, 5'd0, 0, 0, 0, 0, 1, 1, C_LU, 0));
    step(idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 idex_memread  in  1  instruction in EX is a load.
REQ-005 idex_rd  in  5  destination register of the instruction in EX.
REQ-006 ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in ID.
REQ-007 ifid_uses_rs2  in  1  ID instruction reads rs2.
REQ-008 branch_taken  in  1  branch/jump in EX resolved taken.
REQ-009 exmem_memread, exmem_memwrite  in  1 each  data-memory access in MEM.
REQ-010 dmem_ready  in  1  data memory completes the access this cycle.
REQ-011 counter_clr  in  1  clears the performance counters.
REQ-012 pc_write, ifid_write  out  1 each  enable PC and IF/ID updates.
REQ-013 ifid_flush, idex_flush  out  1 each  load NOP into IF/ID and ID/EX.
REQ-014 idex_bubble  out  1  zero the control fields entering ID/EX.
REQ-015 exmem_hold  out  1  freeze the ID/EX and EX/MEM registers.
REQ-016 memwb_bubble  out  1  insert NOP into MEM/WB.
REQ-017 mem_timeout  out  1  sticky error flag.
REQ-018 stall_cycles, flush_count  out  16 each  saturating performance counters.

Function
REQ-019 SHALL implement FSM states RUN and MEM_WAIT; rst forces RUN.
REQ-020 load_use = idex_memread AND idex_rd!=0 AND (idex_rd==ifid_rs1 OR (ifid_uses_rs2 AND idex_rd==ifid_rs2)).
REQ-021 mem_busy = (exmem_memread OR exmem_memwrite) AND NOT dmem_ready.
REQ-022 Priority, highest first: rst, mem_busy, branch_taken, load_use, none.
REQ-023 mem_busy (in either state): pc_write=0, ifid_write=0, exmem_hold=1, memwb_bubble=1, all flush/bubble outputs 0; next state MEM_WAIT.
REQ-024 In MEM_WAIT with dmem_ready=1: outputs follow the lower-priority rules in that same cycle, and the next state is RUN (zero-cycle release).
REQ-025 branch_taken without mem_busy: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; load_use is ignored.
REQ-026 A branch held during MEM_WAIT SHALL flush only in the first cycle in which mem_busy=0.
REQ-027 load_use only: pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle (one bubble); no registered state.
REQ-028 No condition: pc_write=1, ifid_write=1, all other control outputs 0.
REQ-029 All control outputs SHALL be combinational from state and inputs; counters and mem_timeout are registered.
REQ-030 8-bit wait counter: zero in RUN; increments each MEM_WAIT cycle with dmem_ready=0 and saturates at 255.
REQ-031 mem_timeout SHALL set on the edge at which the wait counter reaches 255, and clear only on rst.
REQ-032 stall_cycles SHALL increment on each cycle with pc_write=0 and rst=0, saturating at 0xFFFF.
REQ-033 flush_count SHALL increment on each cycle with ifid_flush=1 and rst=0, saturating at 0xFFFF.
REQ-034 counter_clr SHALL zero both counters on the next edge, overriding any increment in that cycle.

Reset
REQ-035 While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, memwb_bubble=1, idex_bubble=0, exmem_hold=0.
REQ-036 On the first edge with rst=1: state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0, flush_count=0.
REQ-037 Reset asserted during MEM_WAIT SHALL abandon the wait immediately with no further hold cycles.

Verification
REQ-038 Load x5 in EX with ID reading rs1=x5 -> one cycle pc_write=0, idex_bubble=1; stall_cycles +1; with idex_rd=0 -> no stall.
REQ-039 branch_taken=1, no mem op -> ifid_flush=idex_flush=1, pc_write=1 for one cycle; flush_count +1.
REQ-040 exmem_memread=1, dmem_ready low 3 cycles then high -> 3 cycles exmem_hold=1 and memwb_bubble=1; release in the dmem_ready cycle; stall_cycles +3.
REQ-041 branch_taken held during a 2-cycle memory wait -> no flush for 2 cycles; flush in cycle 3.
REQ-042 dmem_ready held low 300 cycles -> mem_timeout=1 after 255 wait cycles and stays 1 after release; clears only on rst.
REQ-043 Counter at 0xFFFF with further stalls -> stays 0xFFFF; counter_clr asserted together with a stall -> 0.
